onehot_scan_decoder: RTL



---
 rtl/decoder_pkg.sv | 21 ++
 rtl/onehot_scan_decoder_ticker.sv | 35 +++
 rtl/onehot_scan_decoder.sv | 70 +++++++
 3 files changed

// File: rtl/decoder_pkg.sv
// Shared constants and helpers for the one-hot scan decoder.
package decoder_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Widest select the helper supports; callers cast the result down to their own width.
  localparam int MAX_SEL_W = 8;
  localparam int MAX_N     = 1 << MAX_SEL_W;

  // Number of decoded lines for a given select width.
  function automatic int n_out(input int sel_w);
    return 1 << sel_w;
  endfunction

  // One-hot image of a select value.
  function automatic logic [MAX_N-1:0] onehot(input int unsigned sel);
    return MAX_N'(1) << sel;
  endfunction

endpackage

// File: rtl/onehot_scan_decoder_ticker.sv
// Dwell counter for scan mode: counts up to dwell, then pulses step and restarts.
module scan_ticker
  import decoder_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               hold,
  input  logic [DWELL_W-1:0] dwell,
  output logic               step
);

  logic [DWELL_W-1:0] dcnt;

  // Live compare: a dwell below dcnt lets the counter run past its maximum and wrap.
  assign step = (dcnt == dwell);

  // Counter update; hold freezes dcnt so a paused scan resumes mid-dwell.
  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt <= '0;
    end else if (hold) begin
      dcnt <= dcnt;
    end else if (clear) begin
      dcnt <= '0;
    end else if (step) begin
      dcnt <= '0;
    end else begin
      dcnt <= dcnt + DWELL_W'(1);
    end
  end

endmodule

// File: rtl/onehot_scan_decoder.sv
// Registered N-to-2^N one-hot decoder with an autonomous scan mode.
module onehot_scan_decoder
  import decoder_pkg::*;
#(
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 8,
  localparam int N_OUT  = n_out(SEL_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic [SEL_W-1:0]   in,
  input  logic [DWELL_W-1:0] dwell,
  output logic [N_OUT-1:0]   out,
  output logic [SEL_W-1:0]   idx,
  output logic               wrap
);

  logic             mode_q;
  logic             step;
  logic             tick_clear;
  logic [SEL_W-1:0] idx_nxt;

  // Counter restarts in direct mode and on the first scan edge.
  assign tick_clear = (mode == MODE_DIRECT) || !mode_q;
  assign idx_nxt    = idx + SEL_W'(1);

  scan_ticker #(.DWELL_W(DWELL_W)) u_ticker (
    .clk   (clk),
    .rst   (rst),
    .clear (tick_clear),
    .hold  (!en),
    .dwell (dwell),
    .step  (step)
  );

  // Index/output/wrap update; mode_q tracks mode even while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out    <= '0;
      idx    <= '0;
      wrap   <= 1'b0;
      mode_q <= MODE_DIRECT;
    end else begin
      mode_q <= mode;
      if (!en) begin
        out  <= '0;
        wrap <= 1'b0;
      end else if (mode == MODE_DIRECT) begin
        idx  <= in;
        out  <= N_OUT'(onehot(int'(in)));
        wrap <= 1'b0;
      end else if (!mode_q) begin
        idx  <= '0;
        out  <= N_OUT'(onehot(0));
        wrap <= 1'b0;
      end else if (step) begin
        idx  <= idx_nxt;
        out  <= N_OUT'(onehot(int'(idx_nxt)));
        wrap <= (idx == SEL_W'(N_OUT - 1));
      end else begin
        // Re-drive current index so re-enabling mid-dwell restores the output at once.
        out  <= N_OUT'(onehot(int'(idx)));
        wrap <= 1'b0;
      end
    end
  end

endmodule
